// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch predictor and the EX-stage
// branch resolution logic.
//   - 2-bit saturating counter encodings and the counter reset value
//   - helpers that extract the table index and BTB tag from a PC
//   - conditional-branch funct3 encodings, which are used by EX-stage resolution
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,  // strongly not-taken
    WNT = 2'b01,  // weakly not-taken
    WT  = 2'b10,  // weakly taken
    ST  = 2'b11   // strongly taken
  } cnt_state_t;

  localparam logic [1:0] CNT_RESET = WNT;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Index is pc[idx_bits+1:2]. The result is zero-extended to 32 bits, and the
  // caller keeps the low idx_bits.
  function automatic logic [31:0] pc_index(input logic [31:0] pc,
                                           input int unsigned idx_bits);
    return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

  // Tag is pc[idx_bits+tag_bits+1:idx_bits+2]. The result is zero-extended to
  // 32 bits.
  function automatic logic [31:0] pc_tag(input logic [31:0] pc,
                                         input int unsigned idx_bits,
                                         input int unsigned tag_bits);
    return (pc >> (idx_bits + 2)) & ((32'd1 << tag_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating direction counter next-state logic (purely combinational).
// Ports:
//   cnt      in  2  current counter value
//   taken    in  1  resolved branch outcome
//   cnt_next out 2  counter value after training with taken
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != ST) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != SNT) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor. It uses a direct-mapped table of 2-bit counters
// and a BTB, both held in flops so that prediction reads are combinational.
// The table is trained non-speculatively from EX-stage branch resolution. The
// module also keeps saturating counts of resolved branches and mispredictions.
//
// Optional build macro: BRANCH_PREDICTOR_GSHARE_EN
//   When defined, a global history register (GHR) is XORed into the counter
//   index. The BTB is still indexed by PC only. When undefined, the predictor is
//   pure bimodal, pred_ghr is 0, and ex_ghr is ignored.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   if_pc                 fetch PC
//   pred_taken/target/hit prediction for if_pc (combinational)
//   pred_ghr              history snapshot to carry with the branch
//   ex_valid/pc/taken/target/mispredict/ghr   resolved conditional branch
//   br_count, mis_count   saturating performance counters
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         if_pc,
  output logic                pred_taken,
  output logic [31:0]         pred_target,
  output logic                pred_hit,
  output logic [IDX_BITS-1:0] pred_ghr,
  input  logic                ex_valid,
  input  logic [31:0]         ex_pc,
  input  logic                ex_taken,
  input  logic [31:0]         ex_target,
  input  logic                ex_mispredict,
  input  logic [IDX_BITS-1:0] ex_ghr,
  output logic [CNT_W-1:0]    br_count,
  output logic [CNT_W-1:0]    mis_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  // Index and tag extraction
  logic [31:0]         if_idx_w, if_tag_w, ex_idx_w, ex_tag_w;
  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic [IDX_BITS-1:0] if_cidx;   // counter index used for prediction
  logic [IDX_BITS-1:0] upd_cidx;  // counter index used for training

  assign if_idx_w = pc_index(if_pc, IDX_BITS);
  assign ex_idx_w = pc_index(ex_pc, IDX_BITS);
  assign if_tag_w = pc_tag(if_pc, IDX_BITS, TAG_BITS);
  assign ex_tag_w = pc_tag(ex_pc, IDX_BITS, TAG_BITS);
  assign if_idx   = if_idx_w[IDX_BITS-1:0];
  assign ex_idx   = ex_idx_w[IDX_BITS-1:0];
  assign if_tag   = if_tag_w[TAG_BITS-1:0];
  assign ex_tag   = ex_tag_w[TAG_BITS-1:0];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_BITS-1:0] ghr_reg;

  // The GHR is updated only by resolved branches, so no recovery is needed on
  // a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_reg <= '0;
    end else if (ex_valid) begin
      ghr_reg <= {ghr_reg[IDX_BITS-2:0], ex_taken};
    end
  end

  assign pred_ghr = ghr_reg;
  assign if_cidx  = if_idx ^ ghr_reg;
  // Training uses the history the branch was predicted with, not the
  // current history.
  assign upd_cidx = ex_idx ^ ex_ghr;

  logic unused_bits;
  assign unused_bits = ^{if_idx_w[31:IDX_BITS], if_tag_w[31:TAG_BITS],
                         ex_idx_w[31:IDX_BITS], ex_tag_w[31:TAG_BITS]};
`else
  assign pred_ghr = '0;
  assign if_cidx  = if_idx;
  assign upd_cidx = ex_idx;

  logic unused_bits;
  assign unused_bits = ^{if_idx_w[31:IDX_BITS], if_tag_w[31:TAG_BITS],
                         ex_idx_w[31:IDX_BITS], ex_tag_w[31:TAG_BITS], ex_ghr};
`endif

  // Table storage, flattened so that the prediction path can mux directly
  logic [ENTRIES-1:0][1:0]          cnt_q;
  logic [ENTRIES-1:0]               valid_q;
  logic [ENTRIES-1:0][TAG_BITS-1:0] tag_q;
  logic [ENTRIES-1:0][31:0]         target_q;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [1:0]          cnt_reg;
      logic [1:0]          cnt_next;
      logic                valid_reg;
      logic [TAG_BITS-1:0] tag_reg;
      logic [31:0]         target_reg;
      logic                cnt_we;
      logic                btb_we;

      // Counter and BTB writes can target different entries when gshare
      // hashing is enabled.
      assign cnt_we = ex_valid && (upd_cidx == IDX_BITS'(gi));
      assign btb_we = ex_valid && ex_taken && (ex_idx == IDX_BITS'(gi));

      sat_counter2 u_sat (
        .cnt      (cnt_reg),
        .taken    (ex_taken),
        .cnt_next (cnt_next)
      );

      // Aliasing PCs share the counter. A tag replacement leaves it untouched.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg   <= CNT_RESET;
          valid_reg <= 1'b0;
        end else begin
          if (cnt_we) cnt_reg <= cnt_next;
          if (btb_we) valid_reg <= 1'b1;
        end
      end

      // Tag and target are qualified by valid_reg, so they need no reset.
      always_ff @(posedge clk) begin
        if (!rst && btb_we) begin
          tag_reg    <= ex_tag;
          target_reg <= ex_target;
        end
      end

      assign cnt_q[gi]    = cnt_reg;
      assign valid_q[gi]  = valid_reg;
      assign tag_q[gi]    = tag_reg;
      assign target_q[gi] = target_reg;
    end
  endgenerate

  // The prediction reads pre-update state. A same-cycle update to the same
  // entry is visible only from the next cycle, because there is no bypass.
  logic rd_hit;
  assign rd_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_hit    = rd_hit;
  assign pred_taken  = rd_hit && cnt_q[if_cidx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

  // Saturating performance counters
  logic [CNT_W-1:0] br_count_reg, mis_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_reg  <= '0;
      mis_count_reg <= '0;
    end else if (ex_valid) begin
      if (br_count_reg != '1) br_count_reg <= br_count_reg + 1'b1;
      if (ex_mispredict && (mis_count_reg != '1)) mis_count_reg <= mis_count_reg + 1'b1;
    end
  end

  assign br_count  = br_count_reg;
  assign mis_count = mis_count_reg;

endmodule
